dct1d_serial: RTL and testbench

- Parametrised, resource-shared successor to the fixed 8-point parallel 1D DCT.
- Accepts one N-point vector on a valid/ready stream and computes the orthonormal forward DCT-II, or the inverse DCT-III, selected per vector.
- Uses a single multiply-accumulate unit stepped by a state machine.
- Sits in the 2D DCT/IDCT path of the codec datapath wherever area matters more than throughput.

---
 rtl/dct1d_serial_if.sv | 27 ++
 rtl/dct1d_serial.sv | 188 ++++++++++++++++++
 tb/tb_dct1d_serial.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dct1d_serial_if.sv
// Stream interface for dct1d_serial: one input vector channel and one result channel.
// Element 0 of each vector sits in the MSBs of its packed bus.
interface dct1d_serial_if #(
    parameter int N         = 8,
    parameter int DinWidth  = 8,
    parameter int DoutWidth = 16
);
    logic                             s_valid_i;
    logic                             s_ready_o;
    logic [0:N-1][DinWidth-1:0]       s_data_i;
    logic                             s_inverse_i;
    logic                             m_valid_o;
    logic                             m_ready_i;
    logic [0:N-1][DoutWidth-1:0]      m_data_o;

    // Transform block side
    modport slave (
        input  s_valid_i, s_data_i, s_inverse_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o
    );

    // Producer / consumer side
    modport master (
        output s_valid_i, s_data_i, s_inverse_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/dct1d_serial.sv
// dct1d_serial: N-point orthonormal forward DCT-II or inverse DCT-III on a
// valid/ready stream, computed with one multiply-accumulate unit over N*N cycles.
module dct1d_serial #(
    parameter int N         = 8,
    parameter int DinWidth  = 8,
    parameter int DinFrac   = 8,
    parameter int DinSigned = 0,
    parameter int DoutWidth = 16,
    parameter int DoutFrac  = 8,
    parameter int CoefWidth = 16
) (
    input logic           clk_i,
    input logic           rst_ni,
    dct1d_serial_if.slave bus
);
    localparam int KW     = $clog2(N);
    localparam int ProdW  = DinWidth + 1 + CoefWidth;
    localparam int AccW   = DinWidth + CoefWidth + $clog2(N) + 1;
    // Distance between the accumulator binary point and the output binary point.
    localparam int Shift  = DinFrac + CoefWidth - 2 - DoutFrac;
    localparam int ShL    = (Shift < 0) ? -Shift : 0;
    localparam int RndW   = AccW + 1 + ShL;
    localparam int SatW   = ((RndW > DoutWidth) ? RndW : DoutWidth) + 1;
    localparam int HalfSh = (Shift > 0) ? Shift - 1 : 0;

    localparam logic signed [RndW-1:0] Half = RndW'(1) <<< HalfSh;
    localparam logic signed [RndW-1:0] One  = RndW'(1);
    localparam logic signed [RndW-1:0] Zero = RndW'(0);
    localparam logic signed [SatW-1:0] MaxV = (SatW'(1) <<< (DoutWidth - 1)) - SatW'(1);
    localparam logic signed [SatW-1:0] MinV = ~MaxV;

    generate
        if (!(N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_n
            $error("dct1d_serial: N must be 2, 4, 8 or 16");
        end
        if (DoutWidth < 2) begin : g_bad_dout
            $error("dct1d_serial: DoutWidth must be at least 2");
        end
        if (CoefWidth < 8) begin : g_bad_coef
            $error("dct1d_serial: CoefWidth must be at least 8");
        end
    endgenerate

    // Row k holds c(k)*cos((2n+1)k*pi/2N) in Q1.(CoefWidth-2), rounded to nearest.
    function automatic logic [N*N*CoefWidth-1:0] build_rom();
        logic [N*N*CoefWidth-1:0] rom;
        real    pi;
        real    scale;
        real    ck;
        real    v;
        integer q;
        rom   = '0;
        pi    = 3.14159265358979323846;
        scale = $pow(2.0, CoefWidth - 2);
        for (int k = 0; k < N; k++) begin
            for (int n = 0; n < N; n++) begin
                ck = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
                v  = ck * $cos((2 * n + 1) * k * pi / (2.0 * N)) * scale;
                q  = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
                rom[(k * N + n) * CoefWidth +: CoefWidth] = CoefWidth'(q);
            end
        end
        return rom;
    endfunction

    localparam logic [N*N*CoefWidth-1:0] Rom = build_rom();

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t                        state_reg;
    logic                          s_ready_reg;
    logic                          m_valid_reg;
    logic                          inverse_reg;
    logic [KW-1:0]                 k_reg;
    logic [KW-1:0]                 n_reg;
    logic signed [AccW-1:0]        acc_reg;
    logic [0:N-1][DinWidth-1:0]    x_reg;
    logic [0:N-1][DoutWidth-1:0]   out_reg;

    int                            coef_idx;
    logic signed [CoefWidth-1:0]   coef;
    logic [DinWidth-1:0]           x_sel;
    logic signed [DinWidth:0]      x_ext;
    logic signed [ProdW-1:0]       prod;
    logic signed [AccW-1:0]        sum;
    logic signed [RndW-1:0]        wide;
    logic signed [RndW-1:0]        rnd;
    logic signed [SatW-1:0]        rnd_ext;
    logic [DoutWidth-1:0]          res;

    assign bus.s_ready_o = s_ready_reg;
    assign bus.m_valid_o = m_valid_reg;
    assign bus.m_data_o  = out_reg;

    // Operand selection and the single MAC; the inverse reads the ROM transposed.
    always_comb begin
        coef_idx = inverse_reg ? (int'(n_reg) * N + int'(k_reg))
                               : (int'(k_reg) * N + int'(n_reg));
        coef     = Rom[coef_idx * CoefWidth +: CoefWidth];
        x_sel    = x_reg[n_reg];
        x_ext    = (DinSigned != 0) ? {x_sel[DinWidth-1], x_sel} : {1'b0, x_sel};
        prod     = ProdW'(x_ext) * ProdW'(coef);
        sum      = acc_reg + AccW'(prod);
        wide     = RndW'(sum);
    end

    // Rescale to the output binary point; right shifts round half away from zero.
    generate
        if (Shift > 0) begin : g_rnd_right
            assign rnd = (wide + Half - (sum[AccW-1] ? One : Zero)) >>> Shift;
        end else if (Shift == 0) begin : g_rnd_none
            assign rnd = wide;
        end else begin : g_rnd_left
            assign rnd = wide <<< ShL;
        end
    endgenerate

    // Clamp the rescaled sum into the signed output range.
    always_comb begin
        rnd_ext = SatW'(rnd);
        if (rnd_ext > MaxV) begin
            res = MaxV[DoutWidth-1:0];
        end else if (rnd_ext < MinV) begin
            res = MinV[DoutWidth-1:0];
        end else begin
            res = rnd_ext[DoutWidth-1:0];
        end
    end

    // Input vector latch; contents are only meaningful once a vector is accepted.
    always_ff @(posedge clk_i) begin
        if (state_reg == IDLE && bus.s_valid_i) begin
            x_reg <= bus.s_data_i;
        end
    end

    // Control FSM with registered handshake outputs, accumulator and result store.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            s_ready_reg <= 1'b1;
            m_valid_reg <= 1'b0;
            inverse_reg <= 1'b0;
            k_reg       <= '0;
            n_reg       <= '0;
            acc_reg     <= '0;
            out_reg     <= '0;
        end else begin
            unique case (state_reg)
                IDLE: begin
                    if (bus.s_valid_i) begin
                        inverse_reg <= bus.s_inverse_i;
                        k_reg       <= '0;
                        n_reg       <= '0;
                        acc_reg     <= '0;
                        s_ready_reg <= 1'b0;
                        state_reg   <= CALC;
                    end
                end
                CALC: begin
                    if (n_reg == KW'(N - 1)) begin
                        out_reg[k_reg] <= res;
                        acc_reg        <= '0;
                        n_reg          <= '0;
                        k_reg          <= k_reg + KW'(1);
                        if (k_reg == KW'(N - 1)) begin
                            m_valid_reg <= 1'b1;
                            state_reg   <= OUT;
                        end
                    end else begin
                        acc_reg <= sum;
                        n_reg   <= n_reg + KW'(1);
                    end
                end
                OUT: begin
                    if (bus.m_ready_i) begin
                        m_valid_reg <= 1'b0;
                        s_ready_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dct1d_serial.sv
// Testbench for dct1d_serial: three configurations (8-bit unsigned in, 16-bit
// signed in, 10-bit out) checked against a cosine-sum reference model.
module tb_dct1d_serial;
    localparam int N = 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   tests = 0;
    int   fails = 0;

    always #5 clk_i = ~clk_i;

    dct1d_serial_if #(.N(N), .DinWidth(8),  .DoutWidth(16)) if_a ();
    dct1d_serial_if #(.N(N), .DinWidth(16), .DoutWidth(16)) if_b ();
    dct1d_serial_if #(.N(N), .DinWidth(8),  .DoutWidth(10)) if_c ();

    dct1d_serial #(.N(N), .DinWidth(8), .DinFrac(8), .DinSigned(0), .DoutWidth(16),
                   .DoutFrac(8), .CoefWidth(16))
        dut_a (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if_a));
    dct1d_serial #(.N(N), .DinWidth(16), .DinFrac(8), .DinSigned(1), .DoutWidth(16),
                   .DoutFrac(8), .CoefWidth(16))
        dut_b (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if_b));
    dct1d_serial #(.N(N), .DinWidth(8), .DinFrac(8), .DinSigned(0), .DoutWidth(10),
                   .DoutFrac(8), .CoefWidth(16))
        dut_c (.clk_i(clk_i), .rst_ni(rst_ni), .bus(if_c));

    // ---------------- reference model ----------------
    function automatic longint coef(input int k, input int n);
        real c;
        real v;
        c = (k == 0) ? $sqrt(1.0 / N) : $sqrt(2.0 / N);
        v = c * $cos(3.14159265358979323846 * (2 * n + 1) * k / (2.0 * N)) * 16384.0;
        return (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
    endfunction

    // Exact integer dot product (fraction 8+14 bits), then round half away
    // from zero to 8 fractional bits and clamp to the output width.
    function automatic longint ref_elem(input longint x[N], input bit inv, input int k,
                                        input int dout_w);
        longint s;
        longint mag;
        longint q;
        longint lim;
        s = 0;
        for (int n = 0; n < N; n++) s += (inv ? coef(n, k) : coef(k, n)) * x[n];
        mag = (s < 0) ? -s : s;
        q   = (mag + 8192) / 16384;
        if (s < 0) q = -q;
        lim = longint'(1) << (dout_w - 1);
        if (q > lim - 1) q = lim - 1;
        if (q < -lim) q = -lim;
        return q;
    endfunction

    function automatic logic [127:0] pack(input longint x[N], input int w);
        logic [127:0] d;
        logic [127:0] mask;
        d    = '0;
        mask = (128'd1 << w) - 128'd1;
        for (int i = 0; i < N; i++) d = (d << w) | (128'(x[i]) & mask);
        return d;
    endfunction

    function automatic longint unpack(input logic [127:0] d, input int i, input int w);
        logic [127:0] t;
        longint v;
        t = d >> ((N - 1 - i) * w);
        v = longint'(t[63:0]) & ((longint'(1) << w) - 1);
        if (v >= (longint'(1) << (w - 1))) v -= (longint'(1) << w);
        return v;
    endfunction

    // ---------------- DUT access ----------------
    task automatic set_in(input int which, input bit v, input logic [127:0] d, input bit inv);
        case (which)
            0: begin if_a.s_valid_i = v; if_a.s_data_i = d[63:0];  if_a.s_inverse_i = inv; end
            1: begin if_b.s_valid_i = v; if_b.s_data_i = d[127:0]; if_b.s_inverse_i = inv; end
            default: begin if_c.s_valid_i = v; if_c.s_data_i = d[63:0]; if_c.s_inverse_i = inv; end
        endcase
    endtask

    function automatic bit s_rdy(input int which);
        case (which)
            0: return if_a.s_ready_o;
            1: return if_b.s_ready_o;
            default: return if_c.s_ready_o;
        endcase
    endfunction

    function automatic bit m_vld(input int which);
        case (which)
            0: return if_a.m_valid_o;
            1: return if_b.m_valid_o;
            default: return if_c.m_valid_o;
        endcase
    endfunction

    function automatic logic [127:0] m_dat(input int which);
        case (which)
            0: return 128'(if_a.m_data_o);
            1: return 128'(if_b.m_data_o);
            default: return 128'(if_c.m_data_o);
        endcase
    endfunction

    // ---------------- checks ----------------
    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp,
                           input longint tol);
        tests++;
        assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
            fails++;
            $error("FAIL %s: got %0d, expected %0d +/- %0d", tag, obs, exp, tol);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where m_valid rose.
    task automatic run_vec(input int which, input logic [127:0] d, input bit inv,
                           output logic [127:0] res, output int lat);
        int guard;
        guard = 0;
        while (!s_rdy(which) && guard < 200) begin
            @(posedge clk_i); #1;
            guard++;
        end
        set_in(which, 1'b1, d, inv);
        @(posedge clk_i); #1;
        set_in(which, 1'b0, {$urandom, $urandom, $urandom, $urandom}, ~inv);
        lat = 0;
        while (!m_vld(which) && lat < 500) begin
            @(posedge clk_i); #1;
            lat++;
        end
        res = m_dat(which);
    endtask

    task automatic check_vec(input string tag, input int which, input longint x[N],
                             input bit inv, input int din_w, input int dout_w,
                             output logic [127:0] res);
        int lat;
        run_vec(which, pack(x, din_w), inv, res, lat);
        chk({tag, " latency"}, lat, N * N);
        for (int k = 0; k < N; k++)
            chk($sformatf("%s out[%0d]", tag, k), unpack(res, k, dout_w),
                ref_elem(x, inv, k, dout_w));
        $display("[TB] %s: inv=%0d out0=%0d out1=%0d latency=%0d", tag, inv,
                 unpack(res, 0, dout_w), unpack(res, 1, dout_w), lat);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        longint       xv[N];
        longint       yv[N];
        longint       orig[N];
        logic [127:0] res;
        logic [127:0] held;
        logic [127:0] snap;
        bit           inv;

        rst_ni = 1'b0;
        set_in(0, 1'b0, '0, 1'b0);
        set_in(1, 1'b0, '0, 1'b0);
        set_in(2, 1'b0, '0, 1'b0);
        if_a.m_ready_i = 1'b1;
        if_b.m_ready_i = 1'b1;
        if_c.m_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset s_ready", longint'(if_a.s_ready_o), 1);
        chk("reset m_valid", longint'(if_a.m_valid_o), 0);
        snap = m_dat(0);
        chk("reset m_data zero", longint'(snap == '0), 1);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // DC
        for (int i = 0; i < N; i++) xv[i] = 128;
        check_vec("dc", 0, xv, 1'b0, 8, 16, res);
        chk_tol("dc out0 abs", unpack(res, 0, 16), 362, 1);
        for (int k = 1; k < N; k++) chk_tol($sformatf("dc out%0d abs", k), unpack(res, k, 16), 0, 1);

        // Ramp
        for (int i = 0; i < N; i++) xv[i] = 32 * i;
        check_vec("ramp", 0, xv, 1'b0, 8, 16, res);
        chk_tol("ramp out0 abs", unpack(res, 0, 16), 317, 1);
        for (int k = 2; k < N; k += 2) chk_tol($sformatf("ramp out%0d abs", k), unpack(res, k, 16), 0, 1);

        // Random unsigned vectors, both directions
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) xv[i] = longint'($urandom_range(0, 255));
            inv = 1'(($urandom_range(0, 1)));
            check_vec($sformatf("rand_a%0d", t), 0, xv, inv, 8, 16, res);
        end

        // Round trip: forward on A, inverse on the signed 16-bit instance
        orig[0] = 32; orig[1] = 224; orig[2] = 0;   orig[3] = 64;
        orig[4] = 96; orig[5] = 192; orig[6] = 128; orig[7] = 160;
        check_vec("rt fwd", 0, orig, 1'b0, 8, 16, res);
        for (int i = 0; i < N; i++) yv[i] = unpack(res, i, 16);
        check_vec("rt inv", 1, yv, 1'b1, 16, 16, res);
        for (int i = 0; i < N; i++) chk_tol($sformatf("rt x[%0d]", i), unpack(res, i, 16), orig[i], 2);

        // Random signed 16-bit vectors
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) xv[i] = longint'($urandom_range(0, 65535)) - 32768;
            inv = 1'(($urandom_range(0, 1)));
            check_vec($sformatf("rand_b%0d", t), 1, xv, inv, 16, 16, res);
        end

        // Saturation on the 10-bit output instance
        for (int i = 0; i < N; i++) xv[i] = 255;
        check_vec("sat", 2, xv, 1'b0, 8, 10, res);
        chk("sat out0 clamp", unpack(res, 0, 10), 511);
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < N; i++) xv[i] = longint'($urandom_range(0, 255));
            inv = 1'(($urandom_range(0, 1)));
            check_vec($sformatf("rand_c%0d", t), 2, xv, inv, 8, 10, res);
        end

        // Backpressure: stall 20 cycles in OUT with ignored input pulses
        if_a.m_ready_i = 1'b0;
        for (int i = 0; i < N; i++) xv[i] = longint'($urandom_range(0, 255));
        check_vec("bp", 0, xv, 1'b0, 8, 16, held);
        for (int c = 0; c < 20; c++) begin
            if (c == 5 || c == 12) set_in(0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
            else                   set_in(0, 1'b0, '0, 1'b0);
            @(posedge clk_i); #1;
            snap = m_dat(0);
            chk($sformatf("bp c%0d data stable", c), longint'(snap == held), 1);
            chk($sformatf("bp c%0d s_ready", c), longint'(if_a.s_ready_o), 0);
            chk($sformatf("bp c%0d m_valid", c), longint'(if_a.m_valid_o), 1);
        end
        set_in(0, 1'b0, '0, 1'b0);
        if_a.m_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("bp release s_ready", longint'(if_a.s_ready_o), 1);
        chk("bp release m_valid", longint'(if_a.m_valid_o), 0);
        snap = m_dat(0);
        chk("bp data held after handshake", longint'(snap == held), 1);
        $display("[TB] bp: stalled 20 cycles, released");
        for (int i = 0; i < N; i++) xv[i] = longint'($urandom_range(0, 255));
        check_vec("bp next", 0, xv, 1'b1, 8, 16, res);

        // Reset in the middle of CALC
        for (int i = 0; i < N; i++) xv[i] = 128;
        set_in(0, 1'b1, pack(xv, 8), 1'b0);
        @(posedge clk_i); #1;
        set_in(0, 1'b0, '0, 1'b0);
        repeat (29) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("midrst s_ready", longint'(if_a.s_ready_o), 1);
        chk("midrst m_valid", longint'(if_a.m_valid_o), 0);
        snap = m_dat(0);
        chk("midrst m_data zero", longint'(snap == '0), 1);
        @(posedge clk_i);
        @(posedge clk_i); #1;
        chk("midrst held s_ready", longint'(if_a.s_ready_o), 1);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        $display("[TB] midrst: reset applied at CALC cycle 30");
        check_vec("post rst dc", 0, xv, 1'b0, 8, 16, res);
        chk_tol("post rst out0 abs", unpack(res, 0, 16), 362, 1);

        repeat (3) @(posedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
